// File: rtl/paralelo_serial_pkg.sv
// Shared constants and state encoding for the paralelo_serial parallel-to-serial stage.
package paralelo_serial_pkg;

   localparam int         WIDTH_DEF      = 8;
   localparam logic [7:0] IDLE_SYM_DEF   = 8'hBC;
   localparam int         SYNC_COUNT_DEF = 4;

   typedef enum logic {
      SYNC   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   function automatic logic [15:0] satInc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/paralelo_serial_if.sv
// Byte-side handshake and serial outputs of paralelo_serial.
// Optional PARALELO_SERIAL_STATS_EN adds the data_count statistics output.
interface paralelo_serial_if
   import paralelo_serial_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);

   logic [WIDTH-1:0] data_in;
   logic             valid_in;
   logic             load;
   logic             data_out;
   logic             synced;
`ifdef PARALELO_SERIAL_STATS_EN
   logic [15:0]      data_count;
`endif

   modport master (
      output data_in, valid_in,
`ifdef PARALELO_SERIAL_STATS_EN
      input  data_count,
`endif
      input  load, data_out, synced
   );

   modport slave (
      input  data_in, valid_in,
`ifdef PARALELO_SERIAL_STATS_EN
      output data_count,
`endif
      output load, data_out, synced
   );

endinterface

// File: rtl/ps_bit_counter.sv
// Modulo-WIDTH bit counter; resets to WIDTH-1 so the first edge after reset is a symbol boundary.
module ps_bit_counter #(
   parameter  int WIDTH = 8,
   localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic clk,
   input  logic reset_L,
   output logic o_wrap
);

   logic [CW-1:0] r_bitCnt;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_bitCnt <= CW'(WIDTH - 1);
      end else if (o_wrap) begin
         r_bitCnt <= '0;
      end else begin
         r_bitCnt <= r_bitCnt + CW'(1);
      end
   end

   assign o_wrap = (r_bitCnt == CW'(WIDTH - 1));

endmodule

// File: rtl/paralelo_serial.sv
// Parallel-to-serial stage: MSB-first serialiser with idle-symbol insertion and a post-reset sync phase.
// Define PARALELO_SERIAL_STATS_EN to add a saturating count of data bytes sent (bus.data_count).
module paralelo_serial
   import paralelo_serial_pkg::*;
#(
   parameter int               WIDTH      = WIDTH_DEF,
   parameter logic [WIDTH-1:0] IDLE_SYM   = IDLE_SYM_DEF,
   parameter int               SYNC_COUNT = SYNC_COUNT_DEF
) (
   input  logic               clk,
   input  logic               reset_L,
   paralelo_serial_if.slave   bus
);

   state_t           r_state;
   state_t           w_stateNext;
   logic [WIDTH-1:0] r_shiftReg;
   logic [WIDTH-1:0] w_shiftNext;
   logic [3:0]       r_syncCnt;
   logic [3:0]       w_syncNext;
   logic             w_load;

   ps_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bitCounter (
      .clk     (clk),
      .reset_L (reset_L),
      .o_wrap  (w_load)
   );

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_state <= SYNC;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_shiftReg <= '0;
         r_syncCnt  <= '0;
      end else begin
         r_shiftReg <= w_shiftNext;
         r_syncCnt  <= w_syncNext;
      end
   end

   // Only symbol boundaries look at the upstream byte; mid-symbol edges just shift.
   always_comb begin
      w_stateNext = r_state;
      w_shiftNext = {r_shiftReg[WIDTH-2:0], 1'b0};
      w_syncNext  = r_syncCnt;
      if (w_load) begin
         case (r_state)
            SYNC: begin
               w_shiftNext = IDLE_SYM;
               w_syncNext  = r_syncCnt + 4'd1;
               if (r_syncCnt == 4'(SYNC_COUNT - 1)) begin
                  w_stateNext = ACTIVE;
               end
            end
            ACTIVE: begin
               w_shiftNext = bus.valid_in ? bus.data_in : IDLE_SYM;
            end
         endcase
      end
   end

   assign bus.data_out = r_shiftReg[WIDTH-1];
   assign bus.load     = w_load;
   assign bus.synced   = (r_state == ACTIVE);

`ifdef PARALELO_SERIAL_STATS_EN
   logic [15:0] r_dataCount;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_dataCount <= '0;
      end else if (w_load && (r_state == ACTIVE) && bus.valid_in) begin
         r_dataCount <= satInc16(r_dataCount);
      end
   end

   assign bus.data_count = r_dataCount;
`endif

endmodule

// File: tb/tb_paralelo_serial.sv
// Self-checking bench for paralelo_serial against a bit-queue reference model.
module tb_paralelo_serial;

   localparam int         W     = 8;
   localparam logic [7:0] IDLE  = 8'hBC;
   localparam int         SYNCN = 4;

   logic clk = 1'b0;
   logic reset_L;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: every sampled symbol is expanded into a queue of bits, MSB first
   bit   expQ[$];
   logic expOut;
   logic expLoad;
   logic expSynced;
   int   loadEdges;
   int   expCount;

   paralelo_serial_if #(.WIDTH(W)) bus ();

   paralelo_serial #(
      .WIDTH      (W),
      .IDLE_SYM   (IDLE),
      .SYNC_COUNT (SYNCN)
   ) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   task automatic modelReset();
      expQ.delete();
      expOut    = 1'b0;
      expLoad   = 1'b1;
      expSynced = 1'b0;
      loadEdges = 0;
      expCount  = 0;
   endtask

   // Drives one clock of input (called at a negedge) and advances the model to the next negedge
   task automatic applyStimulus(input logic [7:0] d, input logic v);
      logic [7:0] sym;
      bus.data_in  = d;
      bus.valid_in = v;
      @(posedge clk);
      cyc++;
      if (expLoad) begin
         sym = (loadEdges < SYNCN || !v) ? IDLE : d;
         if (loadEdges >= SYNCN && v && expCount < 65535) expCount++;
         loadEdges++;
         for (int i = W - 1; i >= 0; i--) expQ.push_back(sym[i]);
      end
      expOut    = expQ.pop_front();
      expLoad   = (expQ.size() == 0);
      expSynced = (loadEdges >= SYNCN);
      @(negedge clk);
   endtask

   task automatic alignToBoundary();
      int n = 0;
      while (!expLoad && n < W) begin
         applyStimulus(8'h00, 1'b0);
         n++;
      end
   endtask

   task automatic pulseReset();
      reset_L = 1'b0;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      reset_L = 1'b1;
   endtask

   task automatic test_reset();
      reset_L      = 1'b0;
      bus.data_in  = 8'h00;
      bus.valid_in = 1'b0;
      modelReset();
      @(negedge clk);
      total++;
      if (bus.data_out !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_data_out got=%b exp=0", bus.data_out);
      end
      total++;
      if (bus.load !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_load got=%b exp=1", bus.load);
      end
      total++;
      if (bus.synced !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_synced got=%b exp=0", bus.synced);
      end
      @(negedge clk);
      reset_L = 1'b1;
   endtask

   task automatic test_sync_stream();
      for (int c = 0; c < 6 * W; c++) begin
         applyStimulus(8'hA5, 1'b1);
         total++;
         if (bus.data_out !== expOut || bus.load !== expLoad || bus.synced !== expSynced) begin
            bad++;
            $display("[TB] FAIL sync_stream cyc=%0d data_out=%b exp=%b load=%b exp=%b synced=%b exp=%b",
                     cyc, bus.data_out, expOut, bus.load, expLoad, bus.synced, expSynced);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat [4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
      alignToBoundary();
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < W; c++) begin
            applyStimulus(pat[s], 1'b1);
            total++;
            if (bus.data_out !== expOut || bus.load !== expLoad || bus.synced !== expSynced) begin
               bad++;
               $display("[TB] FAIL back_to_back cyc=%0d data_out=%b exp=%b load=%b exp=%b synced=%b exp=%b",
                        cyc, bus.data_out, expOut, bus.load, expLoad, bus.synced, expSynced);
            end
         end
      end
   endtask

   task automatic test_idle_insert();
      alignToBoundary();
      for (int c = 0; c < 3 * W; c++) begin
         applyStimulus(8'h55, 1'b0);
         total++;
         if (bus.data_out !== expOut || bus.load !== expLoad) begin
            bad++;
            $display("[TB] FAIL idle_insert cyc=%0d data_out=%b exp=%b load=%b exp=%b",
                     cyc, bus.data_out, expOut, bus.load, expLoad);
         end
      end
   endtask

   task automatic test_reset_mid();
      alignToBoundary();
      for (int c = 0; c < 5; c++) applyStimulus(8'hF1, 1'b1);
      #2;
      reset_L = 1'b0;
      modelReset();
      #1;
      total++;
      if (bus.data_out !== 1'b0 || bus.load !== 1'b1 || bus.synced !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_mid data_out=%b exp=0 load=%b exp=1 synced=%b exp=0",
                  bus.data_out, bus.load, bus.synced);
      end
      @(negedge clk);
      reset_L = 1'b1;
      for (int c = 0; c < 6 * W; c++) begin
         applyStimulus(8'hF1, 1'b1);
         total++;
         if (bus.data_out !== expOut || bus.load !== expLoad || bus.synced !== expSynced) begin
            bad++;
            $display("[TB] FAIL reset_resync cyc=%0d data_out=%b exp=%b load=%b exp=%b synced=%b exp=%b",
                     cyc, bus.data_out, expOut, bus.load, expLoad, bus.synced, expSynced);
         end
      end
   endtask

   task automatic test_valid_glitch();
      logic v;
      alignToBoundary();
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < W; c++) begin
            // Boundary valid alternates per symbol; mid-symbol valid is random noise
            v = (c == 0) ? logic'(s % 2 == 0) : logic'($urandom_range(0, 1));
            applyStimulus(8'h0F, v);
            total++;
            if (bus.data_out !== expOut || bus.load !== expLoad) begin
               bad++;
               $display("[TB] FAIL valid_glitch cyc=%0d data_out=%b exp=%b load=%b exp=%b",
                        cyc, bus.data_out, expOut, bus.load, expLoad);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       v;
      alignToBoundary();
      for (int s = 0; s < 25; s++) begin
         d = 8'($urandom);
         v = ($urandom_range(0, 3) != 0);
         if (s == 7) d = IDLE;
         for (int c = 0; c < W; c++) begin
            if (c == 0) applyStimulus(d, v);
            else        applyStimulus(8'($urandom), logic'($urandom_range(0, 1)));
            total++;
            if (bus.data_out !== expOut || bus.load !== expLoad || bus.synced !== expSynced) begin
               bad++;
               $display("[TB] FAIL random cyc=%0d data_out=%b exp=%b load=%b exp=%b synced=%b exp=%b",
                        cyc, bus.data_out, expOut, bus.load, expLoad, bus.synced, expSynced);
            end
         end
      end
   endtask

`ifdef PARALELO_SERIAL_STATS_EN
   task automatic test_stats();
      logic [12:0] order = 13'b1101101110111;
      pulseReset();
      for (int c = 0; c < SYNCN * W; c++) applyStimulus(8'h3C, 1'b1);
      for (int s = 0; s < 13; s++) begin
         for (int c = 0; c < W; c++) applyStimulus(8'($urandom), order[s]);
      end
      total++;
      if (bus.data_count !== 16'(expCount) || expCount != 10) begin
         bad++;
         $display("[TB] FAIL stats_count got=%0d exp=%0d (model=%0d)", bus.data_count, 10, expCount);
      end
      reset_L = 1'b0;
      modelReset();
      #1;
      total++;
      if (bus.data_count !== 16'd0) begin
         bad++;
         $display("[TB] FAIL stats_reset got=%0d exp=0", bus.data_count);
      end
      @(negedge clk);
      reset_L = 1'b1;
   endtask
`endif

   initial begin
      $display("[TB] paralelo_serial bench start");
      test_reset();
      test_sync_stream();
      test_back_to_back();
      test_idle_insert();
      test_reset_mid();
      test_valid_glitch();
      test_random();
`ifdef PARALELO_SERIAL_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
